// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC register, ROM address, IF/ID register
// Redirects flush IF/ID with a bubble; misaligned redirect targets latch a sticky error.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [31:0]        br_target,
   input  logic               jmp,
   input  logic [31:0]        jmp_target,
   output logic [31:0]        pc,
   output logic               id_valid,
   output logic [31:0]        id_instr,
   output logic [31:0]        id_pc4,
   output logic               align_err
);

   logic [31:0] pc_q, pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic        align_err_q, align_err_d;

   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // The branch belongs to the older instruction, so it outranks a jump in ID.
   always_comb begin
      redirect        = 1'b0;
      redirect_target = 32'h0;
      if (br_taken) begin
         redirect        = 1'b1;
         redirect_target = br_target;
      end else if (jmp) begin
         redirect        = 1'b1;
         redirect_target = jmp_target;
      end
   end

   always_comb begin
      pc_d        = pc_q;
      id_valid_d  = id_valid_q;
      id_instr_d  = id_instr_q;
      id_pc4_d    = id_pc4_q;
      align_err_d = align_err_q;
      if (redirect) begin
         pc_d        = {redirect_target[31:2], 2'b00};
         id_valid_d  = 1'b0;
         id_instr_d  = 32'h0;
         id_pc4_d    = 32'h0;
         align_err_d = align_err_q | (redirect_target[1:0] != 2'b00);
      end else if (!stall) begin
         pc_d       = pc_plus4;
         id_valid_d = 1'b1;
         id_instr_d = imem_data;
         id_pc4_d   = pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         id_valid_q  <= 1'b0;
         id_instr_q  <= 32'h0;
         id_pc4_q    <= 32'h0;
         align_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         id_valid_q  <= id_valid_d;
         id_instr_q  <= id_instr_d;
         id_pc4_q    <= id_pc4_d;
         align_err_q <= align_err_d;
      end
   end

   // Addresses past the ROM span alias by truncation.
   assign imem_addr = pc_q[IMEM_AW+1:2];
   assign pc        = pc_q;
   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc4    = id_pc4_q;
   assign align_err = align_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic [31:0] pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        align_err;

   logic [31:0] rom [64];
   int checks   = 0;
   int failures = 0;

   fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .pc         (pc),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_pc4     (id_pc4),
      .align_err  (align_err)
   );

   always #5 clk = ~clk;

   assign imem_data = rom[imem_addr];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
      br_target = 32'h0; jmp_target = 32'h0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | i;
      rom[0]  = 32'h20020005;
      rom[1]  = 32'h20070003;
      rom[2]  = 32'h2003000c;
      rom[3]  = 32'h00e22025;
      rom[4]  = 32'h00642824;
      rom[14] = 32'h8c070000;
      rom[63] = 32'hDEADBEEF;

      rst_n = 1'b0;
      idle();
      stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
      step(); step();
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_valid", {31'h0, id_valid}, 32'h0);
      check_eq("rst_instr", id_instr, 32'h0);
      check_eq("rst_pc4", id_pc4, 32'h0);
      check_eq("rst_align", {31'h0, align_err}, 32'h0);
      check_eq("rst_addr", {26'h0, imem_addr}, 32'h0);

      rst_n = 1'b1;
      idle();
      step();
      check_eq("seq1_instr", id_instr, 32'h20020005);
      check_eq("seq1_pc4", id_pc4, 32'h4);
      check_eq("seq1_valid", {31'h0, id_valid}, 32'h1);
      check_eq("seq1_pc", pc, 32'h4);
      step();
      check_eq("seq2_instr", id_instr, 32'h20070003);
      check_eq("seq2_pc4", id_pc4, 32'h8);
      step();
      check_eq("seq3_instr", id_instr, 32'h2003000c);
      check_eq("seq3_pc4", id_pc4, 32'hC);
      step();
      check_eq("seq4_instr", id_instr, 32'h00e22025);
      check_eq("seq4_pc", pc, 32'h10);

      stall = 1'b1;
      step(); step();
      check_eq("stall_pc", pc, 32'h10);
      check_eq("stall_instr", id_instr, 32'h00e22025);
      check_eq("stall_pc4", id_pc4, 32'h10);
      check_eq("stall_valid", {31'h0, id_valid}, 32'h1);
      stall = 1'b0;
      step();
      check_eq("unstall_instr", id_instr, 32'h00642824);
      check_eq("unstall_pc", pc, 32'h14);
      check_eq("unstall_pc4", id_pc4, 32'h14);

      br_taken = 1'b1; br_target = 32'h38;
      step();
      check_eq("br_pc", pc, 32'h38);
      check_eq("br_valid", {31'h0, id_valid}, 32'h0);
      check_eq("br_instr", id_instr, 32'h0);
      check_eq("br_pc4", id_pc4, 32'h0);
      idle();
      step();
      check_eq("br_next_instr", id_instr, 32'h8c070000);
      check_eq("br_next_pc4", id_pc4, 32'h3C);
      check_eq("br_next_valid", {31'h0, id_valid}, 32'h1);

      br_taken = 1'b1; br_target = 32'h38;
      jmp = 1'b1; jmp_target = 32'h3C; stall = 1'b1;
      step();
      check_eq("prio_pc", pc, 32'h38);
      check_eq("prio_valid", {31'h0, id_valid}, 32'h0);
      check_eq("prio_instr", id_instr, 32'h0);
      jmp_target = 32'h3F;
      step();
      check_eq("unsel_align", {31'h0, align_err}, 32'h0);
      check_eq("unsel_pc", pc, 32'h38);

      idle();
      jmp = 1'b1; jmp_target = 32'h3E; stall = 1'b1;
      step();
      check_eq("jmp_mis_pc", pc, 32'h3C);
      check_eq("jmp_mis_align", {31'h0, align_err}, 32'h1);
      check_eq("jmp_mis_valid", {31'h0, id_valid}, 32'h0);
      idle();
      step();
      check_eq("post_mis_align", {31'h0, align_err}, 32'h1);
      check_eq("post_mis_instr", id_instr, 32'hA500_000F);
      check_eq("post_mis_pc", pc, 32'h40);
      jmp = 1'b1; jmp_target = 32'h20;
      step();
      check_eq("aligned_keep_align", {31'h0, align_err}, 32'h1);
      check_eq("aligned_pc", pc, 32'h20);
      idle();
      rst_n = 1'b0;
      step();
      check_eq("rst_clr_align", {31'h0, align_err}, 32'h0);
      check_eq("rst_clr_pc", pc, 32'h0);
      rst_n = 1'b1;

      jmp = 1'b1; jmp_target = 32'hFC;
      step();
      check_eq("fc_pc", pc, 32'hFC);
      check_eq("fc_addr", {26'h0, imem_addr}, 32'd63);
      idle();
      step();
      check_eq("alias_pc", pc, 32'h100);
      check_eq("alias_addr", {26'h0, imem_addr}, 32'h0);
      check_eq("alias_instr", id_instr, 32'hDEADBEEF);
      check_eq("alias_pc4", id_pc4, 32'h100);
      check_eq("alias_align", {31'h0, align_err}, 32'h0);

      jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
      step();
      check_eq("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      idle();
      step();
      check_eq("wrap_pc", pc, 32'h0);
      check_eq("wrap_pc4", id_pc4, 32'h0);
      check_eq("wrap_instr", id_instr, 32'hDEADBEEF);
      check_eq("wrap_valid", {31'h0, id_valid}, 32'h1);

      step();
      rst_n = 1'b0; br_taken = 1'b1; br_target = 32'h38;
      step();
      check_eq("rst_br_pc", pc, 32'h0);
      check_eq("rst_br_valid", {31'h0, id_valid}, 32'h0);
      check_eq("rst_br_instr", id_instr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
